// File: rtl/cgra_rf_pkg.sv
// Shared constants, operand-pair type and forwarding helper for the CGRA
// register-file read path.
package cgra_rf_pkg;

  localparam int unsigned DEFAULT_SIZE     = 32;
  localparam int unsigned DEFAULT_LOG2REGS = 1;
  localparam int unsigned MAX_LOG2REGS     = 16;

  typedef logic [MAX_LOG2REGS-1:0] rf_addr_t;

  typedef struct packed {
    logic [DEFAULT_SIZE-1:0] a;
    logic [DEFAULT_SIZE-1:0] b;
  } operand_pair_t;

  // True when a read must take the snooped write data instead of the RF port,
  // i.e. the write lands on the same edge the read address is sampled.
  function automatic logic bypass_select(input logic     wr_en,
                                         input rf_addr_t wr_addr,
                                         input rf_addr_t rd_addr);
    return wr_en && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/cgra_sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty flags and same-cycle
// push+pop; storage and pointers clear on asynchronous active-low reset.
module cgra_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a same-cycle push needs, so push is legal when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Read stage for the 1W/2R CGRA register file: issues read addresses, aligns
// the registered read data with write forwarding, and buffers operand pairs.
module regfile_operand_fetch
  import cgra_rf_pkg::*;
#(
  parameter int unsigned LOG2REGS = DEFAULT_LOG2REGS,
  parameter int unsigned SIZE     = DEFAULT_SIZE,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LOG2REGS-1:0] req_addr0,
  input  logic [LOG2REGS-1:0] req_addr1,
  output logic [LOG2REGS-1:0] rf_address_out0,
  output logic [LOG2REGS-1:0] rf_address_out1,
  input  logic [SIZE-1:0]     rf_out0,
  input  logic [SIZE-1:0]     rf_out1,
  input  logic                wr_en,
  input  logic [LOG2REGS-1:0] wr_addr,
  input  logic [SIZE-1:0]     wr_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [SIZE-1:0]     op_a,
  output logic [SIZE-1:0]     op_b
);

  localparam int unsigned FCW = $clog2(DEPTH) + 1;
  localparam int unsigned OCW = FCW + 1;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } pair_t;

  logic            s1_valid_q, s1_valid_d;
  logic            byp0_q, byp0_d;
  logic            byp1_q, byp1_d;
  logic [SIZE-1:0] byp0_data_q, byp0_data_d;
  logic [SIZE-1:0] byp1_data_q, byp1_data_d;

  logic            accept;
  logic [OCW-1:0]  occupancy;
  pair_t           s1_pair;
  pair_t           head;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;

  assign rf_address_out0 = req_addr0;
  assign rf_address_out1 = req_addr1;

  // Credit counts the pair still in S1, so S1 can always push without stalling.
  assign occupancy = OCW'(fifo_count) + OCW'(s1_valid_q);
  assign req_ready = (occupancy < OCW'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    s1_valid_d  = accept;
    byp0_d      = byp0_q;
    byp1_d      = byp1_q;
    byp0_data_d = byp0_data_q;
    byp1_data_d = byp1_data_q;
    if (accept) begin
      byp0_d      = bypass_select(wr_en, rf_addr_t'(wr_addr), rf_addr_t'(req_addr0));
      byp1_d      = bypass_select(wr_en, rf_addr_t'(wr_addr), rf_addr_t'(req_addr1));
      byp0_data_d = wr_data;
      byp1_data_d = wr_data;
    end
  end

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      s1_valid_q  <= 1'b0;
      byp0_q      <= 1'b0;
      byp1_q      <= 1'b0;
      byp0_data_q <= '0;
      byp1_data_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      byp0_q      <= byp0_d;
      byp1_q      <= byp1_d;
      byp0_data_q <= byp0_data_d;
      byp1_data_q <= byp1_data_d;
    end
  end

  always_comb begin
    s1_pair.a = byp0_q ? byp0_data_q : rf_out0;
    s1_pair.b = byp1_q ? byp1_data_q : rf_out1;
  end

  assign fifo_pop = op_valid && op_ready;

  cgra_sync_fifo #(
    .WIDTH (2 * SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CGRA_Clock),
    .rst_ni  (CGRA_Reset),
    .push_i  (s1_valid_q),
    .data_i  (s1_pair),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign op_valid = !fifo_empty;
  assign op_a     = head.a;
  assign op_b     = head.b;

  s1_push_has_room: assert property (
    @(posedge CGRA_Clock) disable iff (!CGRA_Reset)
    s1_valid_q |-> (!fifo_full || fifo_pop)
  );

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a registered-read RF model and
// a queue scoreboard checked by an independent output monitor.
module tb_regfile_operand_fetch;
  import cgra_rf_pkg::*;

  localparam int unsigned LOG2REGS = 1;
  localparam int unsigned SIZE     = 32;
  localparam int unsigned DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid, req_ready;
  logic [LOG2REGS-1:0] req_addr0, req_addr1;
  logic [LOG2REGS-1:0] rf_address_out0, rf_address_out1;
  logic [SIZE-1:0]     rf_out0, rf_out1;
  logic                wr_en;
  logic [LOG2REGS-1:0] wr_addr;
  logic [SIZE-1:0]     wr_data;
  logic                op_valid, op_ready;
  logic [SIZE-1:0]     op_a, op_b;

  int checks = 0;
  int errors = 0;
  operand_pair_t exp_q[$];

  always #5 clk = ~clk;

  regfile_operand_fetch #(
    .LOG2REGS (LOG2REGS),
    .SIZE     (SIZE),
    .DEPTH    (DEPTH)
  ) dut (
    .CGRA_Clock      (clk),
    .CGRA_Reset      (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr0       (req_addr0),
    .req_addr1       (req_addr1),
    .rf_address_out0 (rf_address_out0),
    .rf_address_out1 (rf_address_out1),
    .rf_out0         (rf_out0),
    .rf_out1         (rf_out1),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_a            (op_a),
    .op_b            (op_b)
  );

  // Register file: reads sample the array before a same-edge write lands.
  logic [SIZE-1:0] rf_regs [2];
  always @(posedge clk) begin
    rf_out0 <= rf_regs[rf_address_out0];
    rf_out1 <= rf_regs[rf_address_out1];
    if (wr_en) rf_regs[wr_addr] <= wr_data;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: empty scoreboard means no pair may be shown; otherwise the head
  // must match the oldest expected pair, which retires on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          check1("no_stale_pair", op_valid, 1'b0);
        end else if (op_valid) begin
          check32("op_a", op_a, exp_q[0].a);
          check32("op_b", op_b, exp_q[0].b);
          if (op_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic a0, input logic a1,
                      input logic we, input logic wa, input logic [SIZE-1:0] wd,
                      input logic rdy, input logic [SIZE-1:0] ea, input logic [SIZE-1:0] eb,
                      output logic acc, output logic ov);
    req_valid = v;
    req_addr0 = a0;
    req_addr1 = a1;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    op_ready  = rdy;
    @(negedge clk);
    acc = v && req_ready;
    ov  = op_valid;
    if (acc) exp_q.push_back('{a: ea, b: eb});
    @(posedge clk);
    #1;
  endtask

  localparam logic [SIZE-1:0] R0A = 32'h11111111;
  localparam logic [SIZE-1:0] R1A = 32'h22222222;
  localparam logic [SIZE-1:0] R1B = 32'hDEADBEEF;
  localparam logic [SIZE-1:0] R1C = 32'h12345678;
  localparam logic [SIZE-1:0] R0D = 32'hCAFEF00D;
  localparam logic [SIZE-1:0] R1E = 32'hA5A5A5A5;

  typedef struct {
    logic            a0;
    logic            a1;
    logic [SIZE-1:0] ea;
    logic [SIZE-1:0] eb;
  } req_t;

  // Register contents at this point: R0 = CAFEF00D, R1 = A5A5A5A5.
  req_t bp_tab [5] = '{
    '{1'b0, 1'b1, R0D, R1E},
    '{1'b1, 1'b0, R1E, R0D},
    '{1'b1, 1'b1, R1E, R1E},
    '{1'b0, 1'b0, R0D, R0D},
    '{1'b0, 1'b1, R0D, R1E}
  };

  initial begin
    logic acc, ov;
    logic b;
    logic ov_hist [19];

    req_valid = 1'b0; req_addr0 = '0; req_addr1 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; op_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check1 ("rst_op_valid", op_valid, 1'b0);
    check32("rst_op_a", op_a, '0);
    check32("rst_op_b", op_b, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Preload and basic read, 2-cycle latency.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, R0A, 1'b1, '0, '0, acc, ov);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, R1A, 1'b1, '0, '0, acc, ov);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, R0A, R1A, acc, ov);
    check1("basic_accept", acc, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
    check1("latency_n1_empty", ov, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
    check1("latency_n2_valid", ov, 1'b1);

    // Same-cycle write is forwarded; a write after accept is not visible.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, R1B, 1'b1, R1B, R0A, acc, ov);
    check1("fwd_accept", acc, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, R1B, R0A, acc, ov);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, R1C, 1'b1, '0, '0, acc, ov);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, R1C, R0A, acc, ov);
    // Both ports forwarded from one write, then only port B forwarded.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, R0D, 1'b1, R0D, R0D, acc, ov);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, R1E, 1'b1, R0D, R1E, acc, ov);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);

    // Back-pressure: four accepts fill the credit, the fifth waits.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bp_tab[i].a0, bp_tab[i].a1, 1'b0, 1'b0, '0, 1'b0,
           bp_tab[i].ea, bp_tab[i].eb, acc, ov);
      check1("bp_accept", acc, 1'b1);
    end
    step(1'b1, bp_tab[4].a0, bp_tab[4].a1, 1'b0, 1'b0, '0, 1'b0, bp_tab[4].ea, bp_tab[4].eb, acc, ov);
    check1("bp_wait_s1", acc, 1'b0);
    step(1'b1, bp_tab[4].a0, bp_tab[4].a1, 1'b0, 1'b0, '0, 1'b0, bp_tab[4].ea, bp_tab[4].eb, acc, ov);
    check1("bp_wait_full", acc, 1'b0);
    step(1'b1, bp_tab[4].a0, bp_tab[4].a1, 1'b0, 1'b0, '0, 1'b1, bp_tab[4].ea, bp_tab[4].eb, acc, ov);
    check1("bp_wait_first_pop", acc, 1'b0);
    step(1'b1, bp_tab[4].a0, bp_tab[4].a1, 1'b0, 1'b0, '0, 1'b1, bp_tab[4].ea, bp_tab[4].eb, acc, ov);
    check1("bp_resume", acc, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);

    // Streaming: 16 back-to-back requests, 16 consecutive output cycles.
    for (int i = 0; i < 19; i++) begin
      if (i < 16) begin
        b = i[0];
        step(1'b1, b, ~b, 1'b0, 1'b0, '0, 1'b1, b ? R1E : R0D, b ? R0D : R1E, acc, ov);
        check1("stream_accept", acc, 1'b1);
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
      end
      ov_hist[i] = ov;
    end
    for (int i = 0; i < 19; i++) begin
      check1("stream_op_valid", ov_hist[i], (i >= 2 && i < 18));
    end

    // Reset with three pairs buffered and one in S1.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bp_tab[i].a0, bp_tab[i].a1, 1'b0, 1'b0, '0, 1'b0,
           bp_tab[i].ea, bp_tab[i].eb, acc, ov);
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check1 ("midrst_op_valid", op_valid, 1'b0);
    check32("midrst_op_a", op_a, '0);
    check32("midrst_op_b", op_b, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("postrst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, R0D, R1E, acc, ov);
    check1("postrst_accept", acc, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, '0, '0, acc, ov);
    end
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
